mul_err_sweep: RTL and testbench
================================

MUL_ERR_SWEEP -- requirements
Module: mul_err_sweep

Interface
REQ-001 Parameter: IN_W, 2, width of each multiplier operand.
REQ-002 Parameter: ET, 5, error threshold; absolute error strictly greater than ET is a violation.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-006 Port: dut_in  output  2*IN_W  stimulus to the approximate multiplier; operand a = dut_in[IN_W-1:0] (in0 = LSB), operand b = dut_in[2*IN_W-1:IN_W].
REQ-007 Port: dut_out  input  2*IN_W  product returned by the approximate multiplier; out0 = bit 0 = LSB, unsigned.
REQ-008 Port: busy  output  1  high while a sweep is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when the sweep completes.
REQ-010 Port: pass  output  1  high when max_err <= ET; valid from done until the next accepted start.
REQ-011 Port: max_err  output  2*IN_W  largest absolute error seen in the sweep.
REQ-012 Port: err_count  output  2*IN_W+1  number of vectors with absolute error > ET.
REQ-013 Port: worst_vec  output  2*IN_W  first vector that reached max_err.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, FINISH.
REQ-015 IDLE: start=1 SHALL clear max_err, err_count, worst_vec and pass, load the vector counter with 0, and go to DRIVE; otherwise remain in IDLE.
REQ-016 dut_in SHALL be driven directly from the registered vector counter and SHALL hold 0 in IDLE.
REQ-017 DRIVE SHALL last exactly one cycle (DUT settle time) and go to SAMPLE.
REQ-018 SAMPLE SHALL compute exact = a*b (2*IN_W bits, no truncation), err = |exact - dut_out| as an unsigned difference with no wrap, and register the updates.
REQ-019 In SAMPLE, if err > max_err then max_err <= err and worst_vec <= current vector; ties SHALL NOT update worst_vec.
REQ-020 In SAMPLE, if err > ET then err_count SHALL increment by 1; the counter cannot overflow because its width holds 2^(2*IN_W).
REQ-021 In SAMPLE, if the vector counter equals all-ones, go to FINISH; otherwise increment the counter and go to DRIVE.
REQ-022 FINISH SHALL assert done for one cycle, register pass = (max_err <= ET) using the final value, and return to IDLE.
REQ-023 Sweep latency: done SHALL be high exactly 2*2^(2*IN_W)+1 cycles after the cycle start is sampled (33 cycles for IN_W=2).
REQ-024 busy SHALL be high in DRIVE, SAMPLE and FINISH, and low in IDLE.
REQ-025 start while busy SHALL be ignored, with no effect on state or results.
REQ-026 Results (max_err, err_count, worst_vec, pass) SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-027 With rst_n=0 at a clock edge: state = IDLE, dut_in = 0, busy = 0, done = 0, pass = 0, max_err = 0, err_count = 0, worst_vec = 0.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no done pulse, and all outputs SHALL take their reset values on that edge.

Verification
REQ-029 Exact 2x2 multiplier attached, start pulse -> done at cycle 33; pass=1, max_err=0, err_count=0, worst_vec=0.
REQ-030 Constant-zero DUT -> max_err=9, worst_vec=4'b1111, err_count=3 (products 6, 6, 9), pass=0.
REQ-031 DUT returns exact+1 -> max_err=1, worst_vec=4'b0000, err_count=0, pass=1.
REQ-032 start re-pulsed at cycles 5 and 20 of a sweep -> ignored; single done at cycle 33 with results unchanged versus an undisturbed run.
REQ-033 rst_n low for one cycle at cycle 12 of a sweep -> all outputs 0 on the next edge, no done; a subsequent start runs a full, correct 33-cycle sweep.
REQ-034 Checker: dut_in SHALL step through 0..15 in order, with each value held for exactly 2 cycles.

Source files
------------

// File: rtl/mul_err_sweep.sv
// mul_err_sweep: exhaustive error sweep of an attached approximate multiplier.
// Every operand pair is presented on dut_in, the returned product is compared
// against the exact product, and the worst-case error, the number of
// threshold violations and the first vector that hit the worst error are
// reported. Each vector takes two cycles: DRIVE lets the external multiplier
// settle, and SAMPLE registers the comparison.
module mul_err_sweep #(
  parameter int IN_W = 2,
  parameter int ET   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [2*IN_W-1:0]   dut_in,
  input  logic [2*IN_W-1:0]   dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*IN_W-1:0]   max_err,
  output logic [2*IN_W:0]     err_count,
  output logic [2*IN_W-1:0]   worst_vec
);

  localparam int VW = 2 * IN_W;
  localparam int CW = 2 * IN_W + 1;
  localparam logic [31:0] ET_L = 32'(ET);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [VW-1:0] vec;
  logic [VW-1:0] op_a;
  logic [VW-1:0] op_b;
  logic [VW-1:0] exact;
  logic [VW-1:0] err;
  logic          last_vec;
  logic          err_over;
  logic          max_ok;

  // Exact product and unsigned absolute error of the current vector.
  always_comb begin
    op_a     = {{IN_W{1'b0}}, vec[IN_W-1:0]};
    op_b     = {{IN_W{1'b0}}, vec[VW-1:IN_W]};
    exact    = op_a * op_b;
    err      = (exact >= dut_out) ? (exact - dut_out) : (dut_out - exact);
    last_vec = (vec == {VW{1'b1}});
    err_over = (32'(err) > ET_L);
    max_ok   = (32'(max_err) <= ET_L);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? FINISH : DRIVE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector counter and result registers. The counter returns to 0 when the
  // last vector is sampled so dut_in is 0 in FINISH and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec       <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_err   <= '0;
      err_count <= '0;
      worst_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            pass      <= 1'b0;
            max_err   <= '0;
            err_count <= '0;
            worst_vec <= '0;
          end
        end
        SAMPLE: begin
          if (err > max_err) begin
            max_err   <= err;
            worst_vec <= vec;
          end
          if (err_over) err_count <= err_count + CW'(1);
          if (last_vec) vec <= '0;
          else          vec <= vec + VW'(1);
        end
        FINISH: begin
          done <= 1'b1;
          pass <= max_ok;
        end
        default: ;
      endcase
    end
  end

  assign dut_in = vec;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mul_err_sweep.sv
// Bench for mul_err_sweep: a behavioural approximate multiplier with several
// error modes feeds the sweeper; each sweep pushes its hand-computed result
// into exp_q and a negedge monitor pops and compares on every done pulse.
module tb_mul_err_sweep;

  localparam int W = 14;  // {pass, max_err[3:0], err_count[4:0], worst_vec[3:0]}

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dut_in;
  logic [3:0] dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] max_err;
  logic [4:0] err_count;
  logic [3:0] worst_vec;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mode = 0;
  int sweep_base = 0;
  bit sweep_chk = 1'b0;

  logic [W-1:0] exp_q[$];
  int           start_q[$];

  mul_err_sweep #(.IN_W(2), .ET(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .max_err   (max_err),
    .err_count (err_count),
    .worst_vec (worst_vec)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Approximate multiplier model with selectable error behaviour
  logic [3:0] prod;
  always_comb begin
    prod = {2'b00, dut_in[1:0]} * {2'b00, dut_in[3:2]};
    case (mode)
      0:       dut_out = prod;
      1:       dut_out = 4'd0;
      2:       dut_out = prod + 4'd1;
      3:       dut_out = 4'hf;
      4:       dut_out = prod + 4'd5;
      5:       dut_out = prod + 4'd6;
      default: dut_out = prod;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: dut_in stepping while a sweep is tracked, and results on done
  logic [W-1:0] mon_exp;
  int           mon_s;
  int           mon_ofs;
  always @(negedge clk) begin
    if (sweep_chk) begin
      mon_ofs = cyc - sweep_base;
      if (mon_ofs >= 1 && mon_ofs <= 32) begin
        check("dut_in_step", 32'(dut_in), 32'((mon_ofs - 1) / 2));
        check("busy_sweep", 32'(busy), 32'd1);
      end else if (mon_ofs == 33) begin
        check("busy_finish", 32'(busy), 32'd1);
        check("dut_in_finish", 32'(dut_in), 32'd0);
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_s   = start_q.pop_front();
        check("done_latency", 32'(cyc - mon_s), 32'd34);
        check("pass", 32'(pass), 32'(mon_exp[13]));
        check("max_err", 32'(max_err), 32'(mon_exp[12:9]));
        check("err_count", 32'(err_count), 32'(mon_exp[8:4]));
        check("worst_vec", 32'(worst_vec), 32'(mon_exp[3:0]));
        check("busy_at_done", 32'(busy), 32'd0);
      end
      done_cnt <= done_cnt + 1;
    end
  end

  // Driver: one sweep, optional start re-pulses mid-sweep, bounded wait for done
  task automatic run_sweep(input int m, input logic [W-1:0] exp, input bit disturb);
    int  d0;
    bit  seen;
    @(negedge clk);
    mode = m;
    d0 = done_cnt;
    exp_q.push_back(exp);
    start_q.push_back(cyc);
    sweep_base = cyc;
    sweep_chk = !disturb ? 1'b1 : 1'b1;
    start = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
      start = (disturb && (i == 5 || i == 20)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    sweep_chk = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    // results must hold in IDLE
    repeat (3) @(negedge clk);
    check("hold_results", 32'({pass, max_err, err_count, worst_vec}), 32'(exp));
    check("idle_dut_in", 32'(dut_in), 32'd0);
  endtask

  // Driver: sweep aborted by a one-cycle reset at offset 12
  task automatic abort_sweep;
    @(negedge clk);
    mode = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_outputs", 32'({dut_in, busy, done, pass, max_err, err_count, worst_vec}), 32'd0);
    // no done may follow; the monitor flags any done with an empty queue
    repeat (40) @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
  endtask

  // Main sequence
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({dut_in, busy, done, pass, max_err, err_count, worst_vec}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'({busy, done}), 32'd0);

    //        mode  {pass, max_err, err_count, worst_vec}       disturb
    run_sweep(0, {1'b1, 4'd0,  5'd0,  4'b0000}, 1'b0);  // exact
    run_sweep(1, {1'b0, 4'd9,  5'd3,  4'b1111}, 1'b0);  // constant zero
    run_sweep(2, {1'b1, 4'd1,  5'd0,  4'b0000}, 1'b0);  // exact+1, ties keep vec 0
    run_sweep(3, {1'b0, 4'd15, 5'd16, 4'b0000}, 1'b0);  // constant 15, every vector over
    run_sweep(4, {1'b1, 4'd5,  5'd0,  4'b0000}, 1'b0);  // error == ET is not a violation
    run_sweep(5, {1'b0, 4'd6,  5'd16, 4'b0000}, 1'b0);  // error == ET+1 everywhere
    run_sweep(1, {1'b0, 4'd9,  5'd3,  4'b1111}, 1'b1);  // start re-pulsed mid-sweep
    abort_sweep();
    run_sweep(1, {1'b0, 4'd9,  5'd3,  4'b1111}, 1'b0);  // full sweep after abort

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
